// File: rtl/mic1_mem_arbiter.sv
// Memory arbiter and stall controller between the mic1 core, a single-ported RAM and a host port.
// Define MIC1_ARB_HOST_EN to build the host port and HOST state; otherwise host outputs are tied to 0.
module mic1_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run_in,
  output logic              core_run,
  input  logic              core_read,
  input  logic              core_write,
  input  logic              core_fetch,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [31:0]       core_addr_instr,
  output logic [31:0]       core_rdata,
  output logic [7:0]        core_rd_instr,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [31:0]       host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy,
  output logic [31:0]       stall_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_FETCH = 3'd3,
    S_WAIT  = 3'd4
`ifdef MIC1_ARB_HOST_EN
    , S_HOST = 3'd5
`endif
  } state_t;

  localparam logic [1:0] SRC_READ  = 2'd0;
  localparam logic [1:0] SRC_FETCH = 2'd1;
`ifdef MIC1_ARB_HOST_EN
  localparam logic [1:0] SRC_HOST  = 2'd2;
`endif
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_served;
  logic [3:0]          r_wait_cnt;
  logic [1:0]          r_src;
  logic [31:0]         r_core_rdata;
  logic [7:0]          r_core_rd_instr;
  logic [31:0]         r_stall_count;
  logic                w_pending;
  logic                w_core_run;
  logic                w_done;
  logic                w_wait_last;
  logic [7:0]          w_lane_byte;
  logic                w_ram_en;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [31:0]         w_ram_wdata;
  logic                w_host_gnt;
  logic                w_unused;

  assign w_pending   = (core_read | core_write | core_fetch) & ~r_served;
  assign w_core_run  = run_in & ~w_pending & resetn;
  assign w_wait_last = (r_state == S_WAIT) && (r_wait_cnt == 4'd0);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state; core ops are served write, read, fetch and skip absent ones
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          if (core_write)     w_state_next = S_WRITE;
          else if (core_read) w_state_next = S_READ;
          else                w_state_next = S_FETCH;
        end
`ifdef MIC1_ARB_HOST_EN
        else if (host_req) begin
          w_state_next = S_HOST;
        end
`endif
      end
      S_WRITE: begin
        if (core_read) begin
          w_state_next = S_READ;
        end else if (core_fetch) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_IDLE;
          w_done       = 1'b1;
        end
      end
      S_READ:  w_state_next = S_WAIT;
      S_FETCH: w_state_next = S_WAIT;
`ifdef MIC1_ARB_HOST_EN
      S_HOST:  w_state_next = host_we ? S_IDLE : S_WAIT;
`endif
      S_WAIT: begin
        if (w_wait_last) begin
          if (r_src == SRC_READ && core_fetch) begin
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_IDLE;
`ifdef MIC1_ARB_HOST_EN
            w_done       = (r_src != SRC_HOST);
`else
            w_done       = 1'b1;
`endif
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    w_host_gnt  = 1'b0;
    case (r_state)
      S_WRITE: begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_addr  = core_addr[ADDR_W-1:0];
        w_ram_wdata = core_wdata;
      end
      S_READ: begin
        w_ram_en   = 1'b1;
        w_ram_addr = core_addr[ADDR_W-1:0];
      end
      S_FETCH: begin
        w_ram_en   = 1'b1;
        w_ram_addr = core_addr_instr[ADDR_W+1:2];
      end
`ifdef MIC1_ARB_HOST_EN
      S_HOST: begin
        w_ram_en    = 1'b1;
        w_ram_we    = host_we;
        w_ram_addr  = host_addr;
        w_ram_wdata = host_wdata;
        w_host_gnt  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Big-endian byte lane: lane 0 is the most significant byte
  always_comb begin
    case (core_addr_instr[1:0])
      2'd0:    w_lane_byte = ram_rdata[31:24];
      2'd1:    w_lane_byte = ram_rdata[23:16];
      2'd2:    w_lane_byte = ram_rdata[15:8];
      default: w_lane_byte = ram_rdata[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_served        <= 1'b0;
      r_wait_cnt      <= 4'd0;
      r_src           <= SRC_READ;
      r_core_rdata    <= 32'd0;
      r_core_rd_instr <= 8'd0;
      r_stall_count   <= 32'd0;
    end else begin
      // Served stays set until the core actually consumes the data
      if (w_done) begin
        r_served <= 1'b1;
      end else if (w_core_run) begin
        r_served <= 1'b0;
      end
      if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end else begin
        r_wait_cnt <= WAIT_LOAD;
      end
      if (r_state == S_READ)  r_src <= SRC_READ;
      if (r_state == S_FETCH) r_src <= SRC_FETCH;
`ifdef MIC1_ARB_HOST_EN
      if (r_state == S_HOST)  r_src <= SRC_HOST;
`endif
      if (w_wait_last && r_src == SRC_READ)  r_core_rdata    <= ram_rdata;
      if (w_wait_last && r_src == SRC_FETCH) r_core_rd_instr <= w_lane_byte;
      if (run_in && !w_core_run && r_stall_count != 32'hFFFF_FFFF) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

`ifdef MIC1_ARB_HOST_EN
  logic        r_host_rvalid;
  logic [31:0] r_host_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= 32'd0;
    end else begin
      r_host_rvalid <= w_wait_last && (r_src == SRC_HOST);
      if (w_wait_last && r_src == SRC_HOST) r_host_rdata <= ram_rdata;
    end
  end

  assign host_rvalid = r_host_rvalid;
  assign host_rdata  = r_host_rdata;
  assign w_unused    = &{1'b0, core_addr[31:ADDR_W], core_addr_instr[31:ADDR_W+2]};
`else
  assign host_rvalid = 1'b0;
  assign host_rdata  = 32'd0;
  assign w_unused    = &{1'b0, core_addr[31:ADDR_W], core_addr_instr[31:ADDR_W+2],
                         host_req, host_we, host_addr, host_wdata};
`endif

  assign core_run      = w_core_run;
  assign core_rdata    = r_core_rdata;
  assign core_rd_instr = r_core_rd_instr;
  assign host_gnt      = w_host_gnt;
  assign ram_en        = w_ram_en;
  assign ram_we        = w_ram_we;
  assign ram_addr      = w_ram_addr;
  assign ram_wdata     = w_ram_wdata;
  assign busy          = (r_state != S_IDLE);
  assign stall_count   = r_stall_count;

endmodule
